jt51_timer_ctrl: RTL and testbench

CPU-side register front end and sequencer for the two YM2151 interval timers. Decodes the address/data write protocol for registers 0x10, 0x11, 0x12 and 0x14. Holds the timer reload values and generates one-cycle control strobes (load, stop, flag clear) plus the CSM key-on pulse. Drives the write-busy status flag. Sits between the CPU bus interface and the timer pair; all outputs connect directly to the timer block.

---
 rtl/jt51_timer_ctrl.sv | 105 ++++++++++
 tb/tb_jt51_timer_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_timer_ctrl.sv
// rtl/jt51_timer_ctrl.sv - YM2151 timer register front end: reload values, control strobes, CSM key-on, write-busy
module jt51_timer_ctrl #(
    parameter int BUSY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_we,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_din,
    input  logic       overflow_A,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       clr_run_A,
    output logic       clr_run_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       csm_kon,
    output logic       busy,
    output logic [7:0] status
);

    localparam logic [7:0] BUSY_INIT = 8'(BUSY_CYCLES);

    logic [7:0] addr;
    logic [7:0] busy_cnt;
    logic       csm;
    logic       ld_A;
    logic       ld_B;
    logic       addr_wr;
    logic       data_wr;

    assign addr_wr = cpu_we & ~cpu_a0;
    // Data writes landing while busy are silently dropped.
    assign data_wr = cpu_we & cpu_a0 & ~busy;
    assign busy    = (busy_cnt != 8'd0);
    assign status  = {busy, 5'b0, flag_B, flag_A};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr         <= 8'd0;
            busy_cnt     <= 8'd0;
            value_A      <= 10'd0;
            value_B      <= 8'd0;
            csm          <= 1'b0;
            ld_A         <= 1'b0;
            ld_B         <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            clr_run_A    <= 1'b0;
            clr_run_B    <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
            csm_kon      <= 1'b0;
        end else begin
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            clr_run_A  <= 1'b0;
            clr_run_B  <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            csm_kon    <= csm & overflow_A;

            if (addr_wr) begin
                addr <= cpu_din;
            end

            if (busy_cnt != 8'd0) begin
                busy_cnt <= busy_cnt - 8'd1;
            end

            if (data_wr) begin
                busy_cnt <= BUSY_INIT;
                case (addr)
                    8'h10: value_A[9:2] <= cpu_din;
                    8'h11: value_A[1:0] <= cpu_din[1:0];
                    8'h12: value_B      <= cpu_din;
                    8'h14: begin
                        csm          <= cpu_din[7];
                        clr_flag_B   <= cpu_din[5];
                        clr_flag_A   <= cpu_din[4];
                        enable_irq_B <= cpu_din[3];
                        enable_irq_A <= cpu_din[2];
                        ld_B         <= cpu_din[1];
                        ld_A         <= cpu_din[0];
                        // Only edges of the ld bits start or stop a timer.
                        load_A       <= cpu_din[0] & ~ld_A;
                        clr_run_A    <= ~cpu_din[0] & ld_A;
                        load_B       <= cpu_din[1] & ~ld_B;
                        clr_run_B    <= ~cpu_din[1] & ld_B;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// tb/tb_jt51_timer_ctrl.sv - scoreboard bench for jt51_timer_ctrl
module tb_jt51_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_we = 1'b0;
    logic       cpu_a0 = 1'b0;
    logic [7:0] cpu_din = 8'd0;
    logic       overflow_A = 1'b0;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B;
    logic       enable_irq_A, enable_irq_B, csm_kon, busy;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];
    logic [7:0] m_addr = 8'd0;
    logic       m_ldA = 1'b0;
    logic       m_ldB = 1'b0;

    jt51_timer_ctrl #(.BUSY_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_a0(cpu_a0), .cpu_din(cpu_din),
        .overflow_A(overflow_A), .flag_A(flag_A), .flag_B(flag_B),
        .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
        .clr_run_A(clr_run_A), .clr_run_B(clr_run_B), .clr_flag_A(clr_flag_A),
        .clr_flag_B(clr_flag_B), .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .csm_kon(csm_kon), .busy(busy), .status(status)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] strobe_vec();
        return {load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B, csm_kon};
    endfunction

    task automatic write_addr(input logic [7:0] a);
        cpu_we = 1'b1; cpu_a0 = 1'b0; cpu_din = a;
        m_addr = a;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    // Drives one data write; the expected strobe set is queued at drive time
    // and popped when the cycle after the sampling edge is observed.
    task automatic write_data(input logic [7:0] d, input logic accepted);
        logic [6:0] e;
        logic [6:0] got;
        e = 7'd0;
        if (accepted && m_addr == 8'h14) begin
            e = {d[0] & ~m_ldA, d[1] & ~m_ldB, ~d[0] & m_ldA, ~d[1] & m_ldB, d[4], d[5], 1'b0};
            m_ldA = d[0];
            m_ldB = d[1];
        end
        exp_q.push_back(e);
        cpu_we = 1'b1; cpu_a0 = 1'b1; cpu_din = d;
        @(negedge clk);
        cpu_we = 1'b0;
        got = strobe_vec();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL strobes_after_write d=%h got %b want %b", d, got, e);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (strobe_vec() !== 7'd0) begin
            errors++;
            $display("FAIL %s got %b want 0000000", name, strobe_vec());
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy=%b after %0d cycles want 0", busy, n);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({value_A, value_B, busy, status, enable_irq_A, enable_irq_B, strobe_vec()} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state got vA=%h vB=%h busy=%b st=%h want all 0", value_A, value_B, busy, status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ldA = 1'b0; m_ldB = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_busy();
        int n;
        write_addr(8'h10);
        write_data(8'hAB, 1'b1);
        checks++;
        if (status !== 8'h80) begin
            errors++;
            $display("FAIL status_busy got %h want 80", status);
        end
        n = (busy === 1'b1) ? 1 : 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL busy_length got %0d want 64", n);
        end
        checks++;
        if (status !== 8'h00) begin
            errors++;
            $display("FAIL status_idle got %h want 00", status);
        end
        write_addr(8'h11);
        write_data(8'hFF, 1'b1);
        wait_idle();
        checks++;
        if (value_A !== 10'h2AF) begin
            errors++;
            $display("FAIL value_A got %h want 2af", value_A);
        end
    endtask

    task automatic test_drop();
        int n;
        write_addr(8'h13);
        write_data(8'h00, 1'b1);
        n = (busy === 1'b1) ? 1 : 0;
        write_addr(8'h12);
        if (busy === 1'b1) n++;
        repeat (7) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        write_data(8'h55, 1'b0);
        if (busy === 1'b1) n++;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL drop_busy_length got %0d want 64", n);
        end
        checks++;
        if (value_B !== 8'h00) begin
            errors++;
            $display("FAIL drop_value_B got %h want 00", value_B);
        end
        write_data(8'h55, 1'b1);
        wait_idle();
        checks++;
        if (value_B !== 8'h55) begin
            errors++;
            $display("FAIL value_B got %h want 55", value_B);
        end
    endtask

    task automatic test_ctrl();
        write_addr(8'h14);
        write_data(8'h05, 1'b1);
        checks++;
        if (enable_irq_A !== 1'b1) begin
            errors++;
            $display("FAIL en_A_set got %b want 1", enable_irq_A);
        end
        @(negedge clk);
        check_quiet("load_A_width");
        wait_idle();
        write_data(8'h05, 1'b1);
        wait_idle();
        write_data(8'h04, 1'b1);
        @(negedge clk);
        check_quiet("clr_run_A_width");
        checks++;
        if (enable_irq_A !== 1'b1) begin
            errors++;
            $display("FAIL en_A_hold got %b want 1", enable_irq_A);
        end
        wait_idle();
    endtask

    task automatic test_flags();
        write_data(8'h32, 1'b1);
        checks++;
        if ({enable_irq_A, enable_irq_B} !== 2'b00) begin
            errors++;
            $display("FAIL en_cleared got %b%b want 00", enable_irq_A, enable_irq_B);
        end
        @(negedge clk);
        check_quiet("flag_strobe_width");
        wait_idle();
        flag_A = 1'b1; flag_B = 1'b1;
        #1;
        checks++;
        if (status !== 8'h03) begin
            errors++;
            $display("FAIL status_flags got %h want 03", status);
        end
        flag_A = 1'b0; flag_B = 1'b0;
    endtask

    task automatic test_csm();
        write_data(8'h80, 1'b1);
        wait_idle();
        overflow_A = 1'b1;
        @(negedge clk);
        overflow_A = 1'b0;
        checks++;
        if (csm_kon !== 1'b1) begin
            errors++;
            $display("FAIL csm_kon_on got %b want 1", csm_kon);
        end
        @(negedge clk);
        check_quiet("csm_kon_width");
        write_data(8'h00, 1'b1);
        overflow_A = 1'b1;
        @(negedge clk);
        overflow_A = 1'b0;
        checks++;
        if (csm_kon !== 1'b0) begin
            errors++;
            $display("FAIL csm_kon_off got %b want 0", csm_kon);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        write_addr(8'h10);
        write_data(8'hFF, 1'b1);
        wait_idle();
        write_addr(8'h11);
        write_data(8'h03, 1'b1);
        wait_idle();
        checks++;
        if (value_A !== 10'h3FF) begin
            errors++;
            $display("FAIL value_A_full got %h want 3ff", value_A);
        end
        write_addr(8'h14);
        write_data(8'h0C, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({value_A, value_B, busy, status, enable_irq_A, enable_irq_B, strobe_vec()} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_busy got vA=%h vB=%h busy=%b st=%h en=%b%b want all 0",
                     value_A, value_B, busy, status, enable_irq_A, enable_irq_B);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ldA = 1'b0; m_ldB = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_busy();
        test_drop();
        test_ctrl();
        test_flags();
        test_csm();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
